spi_ram_burst: RTL and testbench



---
 rtl/spi_ram_pkg.sv | 10 +
 rtl/spi_ram_burst_if.sv | 11 +
 rtl/spi_ram_burst_ram_ptr.sv | 23 ++
 rtl/spi_ram_burst.sv | 61 ++++++
 tb/tb_spi_ram_burst.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcode encoding shared by the burst command RAM and its testbench.
package spi_ram_pkg;
    localparam int OP_W = 2;
    typedef enum logic [OP_W-1:0] {
        OP_SET_WADDR = 2'b00,
        OP_WRITE     = 2'b01,
        OP_SET_RADDR = 2'b10,
        OP_READ      = 2'b11
    } opcode_t;
endpackage

// File: rtl/spi_ram_burst_if.sv
// spi_ram_burst_if: SPI receive command path in, transmit ready/valid path out.
interface spi_ram_burst_if #(parameter int MEM_WIDTH = 8);
    logic [MEM_WIDTH+1:0] din;
    logic                 rx_valid;
    logic                 tx_ready;
    logic [MEM_WIDTH-1:0] dout;
    logic                 tx_valid;
    logic                 ovf;
    modport master (output din, rx_valid, tx_ready, input dout, tx_valid, ovf);
    modport slave  (input din, rx_valid, tx_ready, output dout, tx_valid, ovf);
endinterface

// File: rtl/spi_ram_burst_ram_ptr.sv
// ram_ptr: address pointer with modulo-DEPTH load and wrap-around increment.
module ram_ptr #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);
    logic [WIDTH-1:0] load_mod;
    logic [WIDTH-1:0] ptr_next;
    // True modulo so non-power-of-two depths map out-of-range values correctly
    assign load_mod = WIDTH'(32'(load_val) % DEPTH);
    assign ptr_next = (ptr == WIDTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (load) ptr <= load_mod;
        else if (inc) ptr <= ptr_next;
    end
endmodule

// File: rtl/spi_ram_burst.sv
// spi_ram_burst: tagged-command RAM with auto-incrementing burst pointers
// and a ready/valid read-data output with overrun detection.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int MEM_WIDTH = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_burst_if.slave bus
);
    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
    logic [MEM_WIDTH-1:0] payload;
    logic [ADDR_SIZE-1:0] addr_wr, addr_rd;
    logic [MEM_WIDTH-1:0] dout_q;
    logic                 tx_valid_q, ovf_q;
    opcode_t              op;
    logic                 wr_en, rd_cmd, rd_ok;
    assign op      = opcode_t'(bus.din[MEM_WIDTH+OP_W-1:MEM_WIDTH]);
    assign payload = bus.din[MEM_WIDTH-1:0];
    assign wr_en   = bus.rx_valid && op == OP_WRITE;
    assign rd_cmd  = bus.rx_valid && op == OP_READ;
    // A READ is dropped only while an unconsumed word is still being held
    assign rd_ok   = rd_cmd && (!tx_valid_q || bus.tx_ready);
    ram_ptr #(.DEPTH(MEM_DEPTH), .WIDTH(ADDR_SIZE)) u_wptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bus.rx_valid && op == OP_SET_WADDR),
        .load_val (payload[ADDR_SIZE-1:0]),
        .inc      (wr_en && AUTO_INC),
        .ptr      (addr_wr)
    );
    ram_ptr #(.DEPTH(MEM_DEPTH), .WIDTH(ADDR_SIZE)) u_rptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bus.rx_valid && op == OP_SET_RADDR),
        .load_val (payload[ADDR_SIZE-1:0]),
        .inc      (rd_ok && AUTO_INC),
        .ptr      (addr_rd)
    );
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr_wr] <= payload;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (rd_ok) dout_q <= mem[addr_rd];
            tx_valid_q <= rd_ok ? 1'b1 : (bus.tx_ready ? 1'b0 : tx_valid_q);
            ovf_q      <= rd_cmd && !rd_ok;
        end
    end
    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: directed checks on three configurations (256/inc, 200/inc, 256/hold).
module tb_spi_ram_burst;
    import spi_ram_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    spi_ram_burst_if #(.MEM_WIDTH(8)) ia ();
    spi_ram_burst_if #(.MEM_WIDTH(8)) ib ();
    spi_ram_burst_if #(.MEM_WIDTH(8)) ic ();
    spi_ram_burst #(.MEM_WIDTH(8), .MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.slave));
    spi_ram_burst #(.MEM_WIDTH(8), .MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib.slave));
    spi_ram_burst #(.MEM_WIDTH(8), .MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ic.slave));

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Present one command (or an idle cycle when valid=0) to DUT d, then step past the edge
    task automatic cmd(input int d, input logic [1:0] op, input logic [7:0] pl,
                       input logic rdy, input logic valid = 1'b1);
        case (d)
            0: begin ia.din = {op, pl}; ia.rx_valid = valid; ia.tx_ready = rdy; end
            1: begin ib.din = {op, pl}; ib.rx_valid = valid; ib.tx_ready = rdy; end
            default: begin ic.din = {op, pl}; ic.rx_valid = valid; ic.tx_ready = rdy; end
        endcase
        @(posedge clk);
        #1;
        ia.rx_valid = 1'b0;
        ib.rx_valid = 1'b0;
        ic.rx_valid = 1'b0;
    endtask

    initial begin
        ia.din = '0; ia.rx_valid = 1'b0; ia.tx_ready = 1'b0;
        ib.din = '0; ib.rx_valid = 1'b0; ib.tx_ready = 1'b0;
        ic.din = '0; ic.rx_valid = 1'b0; ic.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk8("rst_dout", ia.dout, 8'h00);
        chk1("rst_tx_valid", ia.tx_valid, 1'b0);
        chk1("rst_ovf", ia.ovf, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Basic write then read
        cmd(0, OP_SET_WADDR, 8'h10, 1'b0);
        cmd(0, OP_WRITE, 8'hA5, 1'b0);
        cmd(0, OP_SET_RADDR, 8'h10, 1'b0);
        chk1("no_read_tx_valid", ia.tx_valid, 1'b0);
        cmd(0, OP_READ, 8'h00, 1'b1);
        chk8("basic_dout", ia.dout, 8'hA5);
        chk1("basic_tx_valid", ia.tx_valid, 1'b1);
        cmd(0, OP_READ, 8'h00, 1'b1, 1'b0);
        chk1("basic_tx_clear", ia.tx_valid, 1'b0);
        chk8("basic_dout_hold", ia.dout, 8'hA5);

        // Burst across the 0xFF -> 0x00 wrap
        cmd(0, OP_SET_WADDR, 8'hFE, 1'b0);
        cmd(0, OP_WRITE, 8'h01, 1'b0);
        cmd(0, OP_WRITE, 8'h02, 1'b0);
        cmd(0, OP_WRITE, 8'h03, 1'b0);
        cmd(0, OP_SET_RADDR, 8'hFE, 1'b1);
        cmd(0, OP_READ, 8'h00, 1'b1);
        chk8("burst0", ia.dout, 8'h01);
        cmd(0, OP_READ, 8'h00, 1'b1);
        chk8("burst1", ia.dout, 8'h02);
        chk1("burst1_valid", ia.tx_valid, 1'b1);
        cmd(0, OP_READ, 8'h00, 1'b1);
        chk8("burst2", ia.dout, 8'h03);
        chk1("burst2_valid", ia.tx_valid, 1'b1);
        cmd(0, OP_READ, 8'h00, 1'b1, 1'b0);
        chk1("burst_clear", ia.tx_valid, 1'b0);

        // Overrun: second READ while a word is pending is dropped
        cmd(0, OP_SET_WADDR, 8'h11, 1'b0);
        cmd(0, OP_WRITE, 8'h66, 1'b0);
        cmd(0, OP_SET_RADDR, 8'h10, 1'b0);
        cmd(0, OP_READ, 8'h00, 1'b0);
        chk8("ovf_first_dout", ia.dout, 8'hA5);
        chk1("ovf_first_noovf", ia.ovf, 1'b0);
        cmd(0, OP_READ, 8'h00, 1'b0);
        chk1("ovf_pulse", ia.ovf, 1'b1);
        chk8("ovf_dout_kept", ia.dout, 8'hA5);
        chk1("ovf_valid_kept", ia.tx_valid, 1'b1);
        cmd(0, OP_READ, 8'h00, 1'b0, 1'b0);
        chk1("ovf_one_cycle", ia.ovf, 1'b0);
        chk1("ovf_valid_held", ia.tx_valid, 1'b1);
        cmd(0, OP_READ, 8'h00, 1'b1, 1'b0);
        chk1("ovf_valid_clear", ia.tx_valid, 1'b0);
        cmd(0, OP_READ, 8'h00, 1'b1);
        chk8("ovf_raddr_once", ia.dout, 8'h66);

        // Non-power-of-two depth: 0xC7 is the last word, 0xD0 reduces to 8, 0xFF to 55
        cmd(1, OP_SET_WADDR, 8'hC7, 1'b1);
        cmd(1, OP_WRITE, 8'h11, 1'b1);
        cmd(1, OP_WRITE, 8'h22, 1'b1);
        cmd(1, OP_SET_RADDR, 8'h00, 1'b1);
        cmd(1, OP_READ, 8'h00, 1'b1);
        chk8("d200_wrap_wr", ib.dout, 8'h22);
        cmd(1, OP_SET_RADDR, 8'hC7, 1'b1);
        cmd(1, OP_READ, 8'h00, 1'b1);
        chk8("d200_last", ib.dout, 8'h11);
        cmd(1, OP_READ, 8'h00, 1'b1);
        chk8("d200_wrap_rd", ib.dout, 8'h22);
        cmd(1, OP_SET_WADDR, 8'h08, 1'b1);
        cmd(1, OP_WRITE, 8'h88, 1'b1);
        cmd(1, OP_SET_RADDR, 8'hD0, 1'b1);
        cmd(1, OP_READ, 8'h00, 1'b1);
        chk8("d200_mod_rd", ib.dout, 8'h88);
        cmd(1, OP_SET_WADDR, 8'hFF, 1'b1);
        cmd(1, OP_WRITE, 8'h37, 1'b1);
        cmd(1, OP_SET_RADDR, 8'h37, 1'b1);
        cmd(1, OP_READ, 8'h00, 1'b1);
        chk8("d200_mod_wr", ib.dout, 8'h37);

        // AUTO_INC=0: pointers hold
        cmd(2, OP_SET_WADDR, 8'h05, 1'b1);
        cmd(2, OP_WRITE, 8'h07, 1'b1);
        cmd(2, OP_WRITE, 8'h08, 1'b1);
        cmd(2, OP_WRITE, 8'h09, 1'b1);
        chk8("noinc_waddr", dut_c.addr_wr, 8'h05);
        cmd(2, OP_SET_RADDR, 8'h05, 1'b1);
        cmd(2, OP_READ, 8'h00, 1'b1);
        chk8("noinc_rd0", ic.dout, 8'h09);
        cmd(2, OP_READ, 8'h00, 1'b1);
        chk8("noinc_rd1", ic.dout, 8'h09);

        // Asynchronous reset while a word is pending
        cmd(0, OP_SET_RADDR, 8'h10, 1'b0);
        cmd(0, OP_READ, 8'h00, 1'b0);
        chk1("arst_pre_valid", ia.tx_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_tx_valid", ia.tx_valid, 1'b0);
        chk8("arst_dout", ia.dout, 8'h00);
        chk1("arst_ovf", ia.ovf, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        cmd(0, OP_SET_RADDR, 8'h10, 1'b1);
        cmd(0, OP_READ, 8'h00, 1'b1);
        chk8("arst_mem_kept0", ia.dout, 8'hA5);
        cmd(0, OP_SET_RADDR, 8'hFE, 1'b1);
        cmd(0, OP_READ, 8'h00, 1'b1);
        chk8("arst_mem_kept1", ia.dout, 8'h01);
        cmd(0, OP_READ, 8'h00, 1'b1);
        chk8("arst_rptr_inc", ia.dout, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
